audio_output_arbiter: RTL

- Shares the single buzzer pin and the 7-bit LED bar among several sound/LED sources: the mode players and a UI confirmation beep.
- Replaces ad-hoc muxing of the shared outputs by the top-level mode controller.
- Grants one owner at a time with a request/grant handshake, a minimum hold time, beep preemption, a timeout and a muted dead gap between owners.

---
 rtl/audio_output_arbiter_pkg.sv | 23 ++
 rtl/audio_output_arbiter_rr_picker.sv | 37 +++
 rtl/audio_output_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/audio_output_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_output_arbiter_pkg
// Purpose  : Shared constants and state encoding for the buzzer/LED arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package audio_output_arbiter_pkg;

  localparam int c_LED_W    = 7;
  localparam int c_BEEP_IDX = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_output_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : audio_output_arbiter_rr_picker
// Purpose  : Round-robin priority encoder over requesters 1..N_REQ-1.
// Revision : 1.0 - initial release
// ============================================================================
module audio_output_arbiter_rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:1] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  int w_cand;

  // i_ptr is always in 1..N_REQ-1, so a single wrap subtraction suffices.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = 0;
    for (int k = 0; k < N_REQ - 1; k++) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand > N_REQ - 1) begin
        w_cand = w_cand - (N_REQ - 1);
      end
      if (!o_valid && i_req[w_cand[IDX_W-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = w_cand[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/audio_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : audio_output_arbiter
// Purpose  : Grants the shared buzzer and LED bar to one source at a time.
// Revision : 1.0 - initial release
// ============================================================================
module audio_output_arbiter
  import audio_output_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int HOLD_TICKS = 20,
  parameter int MAX_TICKS  = 200,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_tick,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ-1:0]         i_buzzer_in,
  input  logic [c_LED_W*N_REQ-1:0] i_led_in,
  output logic [N_REQ-1:0]         o_grant,
  output logic                     o_buzzer,
  output logic [c_LED_W-1:0]       o_led,
  output logic                     o_busy
);

  localparam int c_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int c_CNT_W = $clog2(max_int(max_int(HOLD_TICKS, MAX_TICKS), 1)) + 1;
  localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_HOLD     = c_CNT_W'(HOLD_TICKS);
  localparam logic [c_CNT_W-1:0] c_MAX      = c_CNT_W'(MAX_TICKS);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
  localparam logic [c_IDX_W-1:0] c_BEEP     = c_IDX_W'(c_BEEP_IDX);

  arb_state_t          r_state, w_state_nxt;
  logic [N_REQ-1:0]    r_grant, w_grant_nxt;
  logic [c_IDX_W-1:0]  r_owner, w_owner_nxt;
  logic [c_IDX_W-1:0]  r_rr_ptr, w_rr_nxt;
  logic [c_CNT_W-1:0]  r_hold_cnt, w_hold_nxt;
  logic [c_GAP_W-1:0]  r_gap_cnt, w_gap_nxt;
  logic                r_buzzer, w_buzzer_nxt;
  logic [c_LED_W-1:0]  r_led, w_led_nxt;

  logic [c_LED_W-1:0]  w_led_src [N_REQ];
  logic                w_pick_valid;
  logic [c_IDX_W-1:0]  w_pick_idx;
  logic                w_any_req;
  logic [c_IDX_W-1:0]  w_win_idx;
  logic [N_REQ-1:0]    w_win_oh;
  logic [c_IDX_W-1:0]  w_rr_after;
  logic                w_release, w_preempt, w_timeout, w_exit;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_led_unpack
    assign w_led_src[gi] = i_led_in[gi*c_LED_W +: c_LED_W];
  end

  audio_output_arbiter_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (c_IDX_W)
  ) u_rr_picker (
    .i_req   (i_req[N_REQ-1:1]),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  assign w_any_req  = i_req[c_BEEP_IDX] | w_pick_valid;
  assign w_win_idx  = i_req[c_BEEP_IDX] ? c_BEEP : w_pick_idx;
  assign w_win_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << w_win_idx;
  assign w_rr_after = (r_owner == c_IDX_W'(N_REQ - 1)) ? c_IDX_W'(1) : r_owner + 1'b1;

  // All exit causes lead to the same GAP entry, so their relative priority
  // has no visible effect; r_grant doubles as the owner's one-hot mask.
  assign w_release = ~i_req[r_owner];
  assign w_preempt = (r_owner != c_BEEP) && i_req[c_BEEP_IDX] && (r_hold_cnt >= c_HOLD);
  assign w_timeout = (MAX_TICKS != 0) && (r_hold_cnt >= c_MAX) && (|(i_req & ~r_grant));
  assign w_exit    = w_release | w_preempt | w_timeout;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_owner_nxt  = r_owner;
    w_rr_nxt     = r_rr_ptr;
    w_hold_nxt   = r_hold_cnt;
    w_gap_nxt    = r_gap_cnt;
    w_buzzer_nxt = 1'b0;
    w_led_nxt    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_OWN;
          w_grant_nxt = w_win_oh;
          w_owner_nxt = w_win_idx;
          w_hold_nxt  = '0;
        end
      end
      ST_OWN: begin
        if (w_exit) begin
          w_state_nxt = ST_GAP;
          w_grant_nxt = '0;
          w_gap_nxt   = '0;
          if (r_owner != c_BEEP) begin
            w_rr_nxt = w_rr_after;
          end
        end else begin
          w_buzzer_nxt = i_buzzer_in[r_owner];
          w_led_nxt    = w_led_src[r_owner];
          if (i_tick && (r_hold_cnt != '1)) begin
            w_hold_nxt = r_hold_cnt + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == c_GAP_LAST) begin
          if (w_any_req) begin
            w_state_nxt = ST_OWN;
            w_grant_nxt = w_win_oh;
            w_owner_nxt = w_win_idx;
            w_hold_nxt  = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= c_IDX_W'(1);
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_buzzer   <= 1'b0;
      r_led      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_buzzer   <= w_buzzer_nxt;
      r_led      <= w_led_nxt;
    end
  end

  assign o_grant  = r_grant;
  assign o_buzzer = r_buzzer;
  assign o_led    = r_led;
  assign o_busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire
